// File: rtl/bcd_scan_display.sv
// Two-digit multiplexed 7-segment driver for a 00-99 BCD counter.
// A dark gap separates the digits, and both digits are sampled once per frame.
module bcd_scan_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] MSB,
  input  logic [3:0] LSB,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {S_GAP1, S_LSB, S_GAP0, S_MSB} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      hold_msb_q, hold_msb_d;
  logic [3:0]      hold_lsb_q, hold_lsb_d;
  logic            tick_q, tick_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    hold_msb_d = hold_msb_q;
    hold_lsb_d = hold_lsb_q;
    tick_d     = 1'b0;
    case (state_q)
      S_GAP1: begin
        // The only point where the inputs are sampled; both digits of a frame share it.
        state_d    = S_LSB;
        presc_d    = '0;
        hold_msb_d = MSB;
        hold_lsb_d = LSB;
        tick_d     = 1'b1;
      end
      S_LSB: begin
        if (presc_q == PRESC_TC) begin
          state_d = S_GAP0;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_GAP0: begin
        state_d = S_MSB;
        presc_d = '0;
      end
      S_MSB: begin
        if (presc_q == PRESC_TC) begin
          state_d = S_GAP1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: begin
        state_d = S_GAP1;
        presc_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    an_d  = 2'b11;
    seg_d = SEG_BLANK;
    case (state_d)
      S_LSB: begin
        an_d  = 2'b10;
        seg_d = decode(hold_lsb_d);
      end
      S_MSB: begin
        if (!(LZ_BLANK && (hold_msb_d == 4'd0))) begin
          an_d  = 2'b01;
          seg_d = decode(hold_msb_d);
        end
      end
      default: begin
        an_d  = 2'b11;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_GAP1;
      presc_q    <= '0;
      hold_msb_q <= 4'd0;
      hold_lsb_q <= 4'd0;
      tick_q     <= 1'b0;
      an_q       <= 2'b11;
      seg_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      hold_msb_q <= hold_msb_d;
      hold_lsb_q <= hold_lsb_d;
      tick_q     <= tick_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port SHALL be named clk and the reset port SHALL be named clr.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles each digit is lit per frame; legal range >= 1.
REQ-003 Parameter LZ_BLANK, default 1: 1 = suppress a leading zero on the tens digit.
REQ-004 Port clk: input, 1 bit; rising-edge clock.
REQ-005 Port clr: input, 1 bit; asynchronous, active-high reset.
REQ-006 Port MSB: input, 4 bits; BCD tens digit from the upstream 00-99 counter.
REQ-007 Port LSB: input, 4 bits; BCD units digit from the upstream counter.
REQ-008 Port seg: output, 7 bits; active-low segments, seg[6:0] = {a,b,c,d,e,f,g}.
REQ-009 Port an: output, 2 bits; active-low digit enables, an[0] = units, an[1] = tens.
REQ-010 Port frame_tick: output, 1 bit; one-cycle pulse marking each input snapshot.

Function
REQ-011 The FSM SHALL use four states: S_GAP1, S_LSB, S_GAP0, S_MSB. The order SHALL be S_GAP1 -> S_LSB -> S_GAP0 -> S_MSB -> S_GAP1.
REQ-012 S_LSB and S_MSB SHALL each last exactly REFRESH_DIV cycles, timed by a prescaler running 0..REFRESH_DIV-1; the state SHALL advance at terminal count and the prescaler SHALL then clear.
REQ-013 S_GAP0 and S_GAP1 SHALL each last exactly 1 cycle, so the frame period is 2*REFRESH_DIV+2 cycles.
REQ-014 In the S_GAP1 -> S_LSB transition cycle, MSB and LSB SHALL be captured into hold registers, and frame_tick SHALL be 1 for the first cycle of S_LSB only.
REQ-015 Input changes at any other time SHALL have no effect on the display until the next snapshot, so both digits shown within one frame always come from the same sample.
REQ-016 Outputs SHALL be a Moore function of the state and hold registers only, with no combinational path from MSB/LSB to seg/an.
REQ-017 Gap states: an=2'b11 and seg=7'b1111111.
REQ-018 S_LSB: an=2'b10 and seg=decode(hold_lsb).
REQ-019 S_MSB: an=2'b01 and seg=decode(hold_msb).
REQ-020 Exception in S_MSB: if LZ_BLANK=1 and hold_msb==0, then an=2'b11 and seg=7'b1111111.
REQ-021 Decode, digits 0-4: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
REQ-022 Decode, digits 5-9: 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-023 Decode, codes 10-15: dash 7'b1111110 (segment g only).
REQ-024 At most one an bit SHALL be 0 in any cycle.
REQ-025 REFRESH_DIV=1 SHALL be legal: each lit state lasts 1 cycle and the frame period is 4 cycles.
REQ-026 The prescaler width SHALL be clog2(REFRESH_DIV), with a minimum of 1 bit, and SHALL never exceed REFRESH_DIV-1.

Reset
REQ-027 While clr=1, the block SHALL hold: state=S_GAP1, prescaler=0, hold_msb=hold_lsb=0, an=2'b11, seg=7'b1111111, frame_tick=0.
REQ-028 Assertion of clr mid-frame SHALL force the REQ-027 values immediately, without waiting for a clock edge.
REQ-029 At the first rising clk edge after clr deasserts, the block SHALL take a snapshot and enter S_LSB, with frame_tick=1 in that first S_LSB cycle.

Verification (REFRESH_DIV=4 unless noted)
REQ-030 Scenario: hold clr=1 for 3 cycles -> an=11, seg=1111111, frame_tick=0 throughout.
REQ-031 Scenario: MSB=4, LSB=2, release clr -> frame_tick=1 on cycle 1, then:
  - 4 cycles an=10, seg=0010010;
  - 1 cycle an=11;
  - 4 cycles an=01, seg=1001100;
  - 1 cycle an=11;
  - repeat with a 10-cycle period.
REQ-032 Scenario: change LSB from 2 to 7 during S_MSB -> seg stays unchanged until the next frame_tick, and units shows 0001111 in the following frame.
REQ-033 Scenario: MSB=0, LSB=5, LZ_BLANK=1 -> an=11 during S_MSB. With LZ_BLANK=0 -> an=01 and seg=0000001 during S_MSB.
REQ-034 Scenario: LSB=4'hA, MSB=4'hF -> both digit slots show 1111110.
REQ-035 Scenario: pulse clr for 1 ns during S_MSB -> an=11 and seg=1111111 within that cycle. After release, the snapshot and S_LSB follow on the next edge; the an one-hot-low assertion SHALL hold throughout.
